// File: rtl/axil_apb_bridge_tmo.sv
// AXI4-Lite to APB4 bridge: programmable address map, DECERR for unmapped addresses,
// per-transfer ACCESS timeout with sticky flag, and fair read/write arbitration.
module axil_apb_bridge_tmo #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned NO_APB_SLAVES = 8,
    parameter int unsigned NO_APB_RULES  = 8,
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter int unsigned IDX_W         = (NO_APB_SLAVES > 1) ? $clog2(NO_APB_SLAVES) : 1,
    localparam int unsigned STRB_W       = DATA_W / 8
) (
    input  logic                            PCLKMST_PCLK,
    input  logic                            PRSTnMS_PCLK,
    input  logic [ADDR_W-1:0]               s_aw_addr,
    input  logic [2:0]                      s_aw_prot,
    input  logic                            s_aw_valid,
    output logic                            s_aw_ready,
    input  logic [DATA_W-1:0]               s_w_data,
    input  logic [STRB_W-1:0]               s_w_strb,
    input  logic                            s_w_valid,
    output logic                            s_w_ready,
    output logic [1:0]                      s_b_resp,
    output logic                            s_b_valid,
    input  logic                            s_b_ready,
    input  logic [ADDR_W-1:0]               s_ar_addr,
    input  logic [2:0]                      s_ar_prot,
    input  logic                            s_ar_valid,
    output logic                            s_ar_ready,
    output logic [DATA_W-1:0]               s_r_data,
    output logic [1:0]                      s_r_resp,
    output logic                            s_r_valid,
    input  logic                            s_r_ready,
    input  logic [NO_APB_RULES*ADDR_W-1:0]  map_start_i,
    input  logic [NO_APB_RULES*ADDR_W-1:0]  map_end_i,
    input  logic [NO_APB_RULES*IDX_W-1:0]   map_idx_i,
    output logic [ADDR_W-1:0]               apb_paddr_o,
    output logic [2:0]                      apb_pprot_o,
    output logic [NO_APB_SLAVES-1:0]        apb_pselx_o,
    output logic                            apb_penable_o,
    output logic                            apb_pwrite_o,
    output logic [DATA_W-1:0]               apb_pwdata_o,
    output logic [STRB_W-1:0]               apb_pstrb_o,
    input  logic [NO_APB_SLAVES-1:0]        apb_pready_i,
    input  logic [NO_APB_SLAVES-1:0]        apb_pslverr_i,
    input  logic [NO_APB_SLAVES*DATA_W-1:0] apb_prdata_i,
    output logic                            tmo_flag_o,
    input  logic                            tmo_clr_i,
    output logic                            busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              r_state, w_state_next;
    logic                r_prio_wr;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_prot;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic [IDX_W-1:0]    r_sel_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_resp;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_tmo_flag;

    logic                w_wr_req, w_rd_req, w_contest;
    logic                w_grant_wr, w_grant_rd, w_accept;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_hit, w_mapped;
    logic [IDX_W-1:0]    w_idx;
    logic [NO_APB_SLAVES-1:0] w_sel_onehot;
    logic                w_pready, w_pslverr;
    logic [DATA_W-1:0]   w_prdata;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout, w_tmo_hit;

    assign w_wr_req  = s_aw_valid & s_w_valid;
    assign w_rd_req  = s_ar_valid;
    assign w_contest = w_wr_req & w_rd_req;

    // r_prio_wr only moves on a contested grant; a lone request never shifts priority.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (r_state == StIdle && PRSTnMS_PCLK) begin
            if (w_contest) begin
                w_grant_wr = r_prio_wr;
                w_grant_rd = !r_prio_wr;
            end else begin
                w_grant_wr = w_wr_req;
                w_grant_rd = w_rd_req;
            end
        end
    end

    assign w_accept   = w_grant_wr | w_grant_rd;
    assign w_req_addr = w_grant_wr ? s_aw_addr : s_ar_addr;

    // Scan from the top so the lowest-numbered matching rule is the last to write.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int r = NO_APB_RULES - 1; r >= 0; r--) begin
            if (w_req_addr >= map_start_i[r*ADDR_W +: ADDR_W] &&
                w_req_addr <= map_end_i[r*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_idx = map_idx_i[r*IDX_W +: IDX_W];
            end
        end
    end

    assign w_mapped = w_hit && (32'(w_idx) < NO_APB_SLAVES);

    always_comb begin
        w_sel_onehot = '0;
        w_pready     = 1'b0;
        w_pslverr    = 1'b0;
        w_prdata     = '0;
        for (int s = 0; s < NO_APB_SLAVES; s++) begin
            if (r_sel_idx == IDX_W'(s)) begin
                w_sel_onehot[s] = 1'b1;
                w_pready        = apb_pready_i[s];
                w_pslverr       = apb_pslverr_i[s];
                w_prdata        = apb_prdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    // The abort decision is taken in the last ACCESS cycle, so the response follows one cycle
    // later, just like a pready completion.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));
    assign w_tmo_hit = (r_state == StAccess) && !w_pready && w_timeout;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = w_mapped ? StSetup : StResp;
            StSetup:  w_state_next = StAccess;
            StAccess: if (w_pready || w_timeout) w_state_next = StResp;
            StResp:   if (r_write ? s_b_ready : s_r_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge PCLKMST_PCLK) begin
        if (!PRSTnMS_PCLK) begin
            r_state    <= StIdle;
            r_prio_wr  <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_prot     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_sel_idx  <= '0;
            r_cnt      <= '0;
            r_resp     <= '0;
            r_rdata    <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write   <= w_grant_wr;
                r_addr    <= w_req_addr;
                r_prot    <= w_grant_wr ? s_aw_prot : s_ar_prot;
                r_wdata   <= w_grant_wr ? s_w_data : '0;
                r_strb    <= w_grant_wr ? s_w_strb : '0;
                r_sel_idx <= w_idx;
                r_cnt     <= '0;
                r_resp    <= w_mapped ? RespOkay : RespDecErr;
                r_rdata   <= '0;
                if (w_contest) r_prio_wr <= w_grant_rd;
            end
            if (r_state == StAccess) begin
                if (w_pready) begin
                    r_resp  <= w_pslverr ? RespSlvErr : RespOkay;
                    r_rdata <= (!r_write && !w_pslverr) ? w_prdata : '0;
                end else if (w_timeout) begin
                    r_resp  <= RespSlvErr;
                    r_rdata <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
            if (w_tmo_hit) begin
                r_tmo_flag <= 1'b1;
            end else if (tmo_clr_i) begin
                r_tmo_flag <= 1'b0;
            end
        end
    end

    assign s_aw_ready    = w_grant_wr;
    assign s_w_ready     = w_grant_wr;
    assign s_ar_ready    = w_grant_rd;
    assign s_b_valid     = (r_state == StResp) && r_write;
    assign s_b_resp      = r_write ? r_resp : 2'b00;
    assign s_r_valid     = (r_state == StResp) && !r_write;
    assign s_r_resp      = r_write ? 2'b00 : r_resp;
    assign s_r_data      = r_rdata;
    assign apb_pselx_o   = (r_state == StSetup || r_state == StAccess) ? w_sel_onehot : '0;
    assign apb_penable_o = (r_state == StAccess);
    assign apb_pwrite_o  = r_write;
    assign apb_paddr_o   = r_addr;
    assign apb_pprot_o   = r_prot;
    assign apb_pwdata_o  = r_wdata;
    assign apb_pstrb_o   = r_strb;
    assign busy_o        = (r_state != StIdle);
    assign tmo_flag_o    = r_tmo_flag;

endmodule

// File: tb/tb_axil_apb_bridge_tmo.sv
// Directed and randomized bench for axil_apb_bridge_tmo with a transaction-level model of
// address decode, response codes, arbitration order, timeout and the sticky flag.
module tb_axil_apb_bridge_tmo;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 6;
    localparam int NR  = 8;
    localparam int TMO = 4;
    localparam int IW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [AW-1:0]  aw_addr, ar_addr;
    logic [2:0]     aw_prot, ar_prot;
    logic           aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
    logic [DW-1:0]  w_data, r_data;
    logic [3:0]     w_strb;
    logic [1:0]     b_resp, r_resp;
    logic           b_valid, b_ready, r_valid, r_ready;
    logic [NR*AW-1:0] map_start, map_end;
    logic [NR*IW-1:0] map_idx;
    logic [AW-1:0]  paddr;
    logic [2:0]     pprot;
    logic [NS-1:0]  pselx, pready, pslverr;
    logic           penable, pwrite, tmo_flag, tmo_clr, busy;
    logic [DW-1:0]  pwdata;
    logic [3:0]     pstrb;
    logic [NS*DW-1:0] prdata;

    axil_apb_bridge_tmo #(
        .ADDR_W(AW), .DATA_W(DW), .NO_APB_SLAVES(NS), .NO_APB_RULES(NR), .TIMEOUT_CYC(TMO),
        .IDX_W(IW)
    ) dut (
        .PCLKMST_PCLK(clk), .PRSTnMS_PCLK(rst_n),
        .s_aw_addr(aw_addr), .s_aw_prot(aw_prot), .s_aw_valid(aw_valid), .s_aw_ready(aw_ready),
        .s_w_data(w_data), .s_w_strb(w_strb), .s_w_valid(w_valid), .s_w_ready(w_ready),
        .s_b_resp(b_resp), .s_b_valid(b_valid), .s_b_ready(b_ready),
        .s_ar_addr(ar_addr), .s_ar_prot(ar_prot), .s_ar_valid(ar_valid), .s_ar_ready(ar_ready),
        .s_r_data(r_data), .s_r_resp(r_resp), .s_r_valid(r_valid), .s_r_ready(r_ready),
        .map_start_i(map_start), .map_end_i(map_end), .map_idx_i(map_idx),
        .apb_paddr_o(paddr), .apb_pprot_o(pprot), .apb_pselx_o(pselx),
        .apb_penable_o(penable), .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata),
        .apb_pstrb_o(pstrb), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
        .apb_prdata_i(prdata), .tmo_flag_o(tmo_flag), .tmo_clr_i(tmo_clr), .busy_o(busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] rs [NR];
    logic [31:0] re [NR];
    int          ri [NR];

    bit prio_wr = 1'b0;  // model: next contested grant goes to write
    bit exp_tmo = 1'b0;

    // APB slave model: the expected target answers after cur_ws wait states, every other
    // slave claims ready so a wrong pready mux finishes early.
    int cur_slave = -1;
    int cur_ws    = 0;
    bit cur_err   = 1'b0;
    int acc       = 0;

    initial begin
        pready  = '0;
        pslverr = '0;
        forever begin
            @(negedge clk);
            if (penable) acc++;
            else acc = 0;
            pready  = '1;
            pslverr = NS'($urandom);
            if (cur_slave >= 0) begin
                pready[cur_slave]  = penable && (acc == cur_ws + 1);
                pslverr[cur_slave] = cur_err;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_target(input logic [31:0] a);
        for (int j = 0; j < NR; j++) begin
            if (a >= rs[j] && a <= re[j]) return (ri[j] < NS) ? ri[j] : -1;
        end
        return -1;
    endfunction

    task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot);
        if (wr) begin
            aw_addr = addr; aw_prot = prot; w_data = data; w_strb = strb;
            aw_valid = 1'b1; w_valid = 1'b1;
        end else begin
            ar_addr = addr; ar_prot = prot; ar_valid = 1'b1;
        end
    endtask

    task automatic serve(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input int ws,
                         input bit err, input int stall, input bit clr_at_tmo,
                         input logic [31:0] fixed_rd);
        int tgt = model_target(addr);
        bit tmo = (tgt >= 0) && (ws >= TMO);
        int n_acc = tmo ? TMO : ws + 1;
        int resp_k = (tgt < 0) ? 1 : 2 + n_acc;
        logic [1:0] exp_resp;
        logic [31:0] exp_rdata;
        logic [NS-1:0] exp_sel = '0;
        bit got = 1'b0;
        for (int s = 0; s < NS; s++) prdata[s*DW +: DW] = $urandom;
        if (tgt >= 0) begin
            exp_sel[tgt] = 1'b1;
            if (fixed_rd != 0) prdata[tgt*DW +: DW] = fixed_rd;
        end
        exp_resp  = (tgt < 0) ? 2'b11 : ((tmo || err) ? 2'b10 : 2'b00);
        exp_rdata = (!wr && exp_resp == 2'b00) ? prdata[tgt*DW +: DW] : 32'h0;
        cur_slave = tgt; cur_ws = ws; cur_err = err;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (wr ? (aw_ready && w_ready) : ar_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("handshake_seen", 64'(got), 64'(1));
        if (!got) begin
            aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
            return;
        end
        chk("other_ready_low", 64'(wr ? ar_ready : aw_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        if (wr) begin aw_valid = 1'b0; w_valid = 1'b0; end
        else ar_valid = 1'b0;
        for (int k = 1; k <= resp_k; k++) begin
            bit in_setup = (tgt >= 0) && (k == 1);
            bit in_acc   = (tgt >= 0) && (k >= 2) && (k < resp_k);
            if (k > 1) @(negedge clk);
            chk("pselx", 64'(pselx), 64'((in_setup || in_acc) ? exp_sel : '0));
            chk("penable", 64'(penable), 64'(in_acc));
            chk("busy", 64'(busy), 64'(1));
            chk("ready_while_busy", 64'({aw_ready, w_ready, ar_ready}), 64'(0));
            if (in_setup) begin
                chk("paddr", 64'(paddr), 64'(addr));
                chk("pwrite", 64'(pwrite), 64'(wr));
                chk("pprot", 64'(pprot), 64'(prot));
                chk("pwdata", 64'(pwdata), 64'(wr ? data : 32'h0));
                chk("pstrb", 64'(pstrb), 64'(wr ? strb : 4'h0));
            end
            if (k < resp_k) chk("early_valid", 64'(b_valid | r_valid), 64'(0));
            tmo_clr = (tmo && clr_at_tmo && k == resp_k - 1);
        end
        if (tmo) exp_tmo = 1'b1;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            tmo_clr = 1'b0;
            chk("b_valid", 64'(b_valid), 64'(wr));
            chk("r_valid", 64'(r_valid), 64'(!wr));
            if (wr) chk("b_resp", 64'(b_resp), 64'(exp_resp));
            else begin
                chk("r_resp", 64'(r_resp), 64'(exp_resp));
                chk("r_data", 64'(r_data), 64'(exp_rdata));
            end
            chk("tmo_flag", 64'(tmo_flag), 64'(exp_tmo));
            chk("pselx_resp", 64'(pselx), 64'(0));
            if (s == stall) begin
                if (wr) b_ready = 1'b1;
                else r_ready = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;
        chk("valid_after_hs", 64'(b_valid | r_valid), 64'(0));
        chk("idle_after_hs", 64'(busy), 64'(0));
        cur_slave = -1;
    endtask

    task automatic pair(input logic [31:0] ra, input int rws, input bit rerr,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wst,
                        input int wws, input bit werr, input int stall, input logic [31:0] frd);
        bit win_wr = prio_wr;
        logic [2:0] rp = 3'($urandom);
        logic [2:0] wp = 3'($urandom);
        start_req(1'b0, ra, 32'h0, 4'h0, rp);
        start_req(1'b1, wa, wd, wst, wp);
        prio_wr = !win_wr;
        if (win_wr) begin
            serve(1'b1, wa, wd, wst, wp, wws, werr, stall, 1'b0, 32'h0);
            serve(1'b0, ra, 32'h0, 4'h0, rp, rws, rerr, 0, 1'b0, frd);
        end else begin
            serve(1'b0, ra, 32'h0, 4'h0, rp, rws, rerr, 0, 1'b0, frd);
            serve(1'b1, wa, wd, wst, wp, wws, werr, stall, 1'b0, 32'h0);
        end
    endtask

    task automatic clear_flag();
        tmo_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tmo_clr = 1'b0;
        exp_tmo = 1'b0;
        chk("tmo_clear", 64'(tmo_flag), 64'(0));
    endtask

    initial begin
        rs[0] = 32'h0013_0000; re[0] = 32'h0013_01FF; ri[0] = 0;
        rs[1] = 32'h0013_0200; re[1] = 32'h0013_03FF; ri[1] = 1;
        rs[2] = 32'h0014_0000; re[2] = 32'h0014_FFFF; ri[2] = 2;
        rs[3] = 32'h0015_0000; re[3] = 32'h0015_FFFF; ri[3] = 7;
        rs[4] = 32'h0014_8000; re[4] = 32'h0014_FFFF; ri[4] = 4;
        rs[5] = 32'h0016_0000; re[5] = 32'h0016_FFFF; ri[5] = 5;
        rs[6] = 32'h0017_0000; re[6] = 32'h0017_FFFF; ri[6] = 3;
        rs[7] = 32'h0018_0010; re[7] = 32'h0018_0000; ri[7] = 0;
        for (int j = 0; j < NR; j++) begin
            map_start[j*AW +: AW] = rs[j];
            map_end[j*AW +: AW]   = re[j];
            map_idx[j*IW +: IW]   = IW'(ri[j]);
        end
        prdata = '0;
        tmo_clr = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        // Reset with requests pending: every output must stay 0.
        rst_n = 1'b0;
        start_req(1'b1, 32'h0013_0010, 32'hFFFF_FFFF, 4'hF, 3'h7);
        start_req(1'b0, 32'h0013_0200, 32'h0, 4'h0, 3'h7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({aw_ready, w_ready, ar_ready}), 64'(0));
        chk("rst_valid", 64'({b_valid, r_valid}), 64'(0));
        chk("rst_resp_data", 64'({b_resp, r_resp, r_data}), 64'(0));
        chk("rst_apb", 64'({pselx, penable, pwrite, pstrb}), 64'(0));
        chk("rst_apb_data", 64'({paddr, pwdata}), 64'(0));
        chk("rst_status", 64'({busy, tmo_flag}), 64'(0));
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Contest right after reset: read (2 wait states) first, then the write.
        pair(32'h0013_0200, 2, 1'b0, 32'h0013_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0,
             32'h1234_5678);
        // Same pair again: write wins and its response is stalled.
        pair(32'h0013_0204, 1, 1'b0, 32'h0013_0014, 32'hCAFE_0001, 4'h3, 1, 1'b1, 3, 32'h0);
        // Unmapped: no rule, index out of range, shadowed rule, empty rule, last-cycle pready.
        start_req(1'b0, 32'h0020_0000, 32'h0, 4'h0, 3'h0);
        serve(1'b0, 32'h0020_0000, 32'h0, 4'h0, 3'h0, 0, 1'b0, 0, 1'b0, 32'h0);
        start_req(1'b0, 32'h0015_0004, 32'h0, 4'h0, 3'h1);
        serve(1'b0, 32'h0015_0004, 32'h0, 4'h0, 3'h1, 0, 1'b0, 1, 1'b0, 32'h0);
        start_req(1'b1, 32'h0014_9000, 32'h0BAD_F00D, 4'h5, 3'h2);
        serve(1'b1, 32'h0014_9000, 32'h0BAD_F00D, 4'h5, 3'h2, 1, 1'b0, 0, 1'b0, 32'h0);
        start_req(1'b1, 32'h0018_0008, 32'h5555_AAAA, 4'hF, 3'h0);
        serve(1'b1, 32'h0018_0008, 32'h5555_AAAA, 4'hF, 3'h0, 0, 1'b0, 0, 1'b0, 32'h0);
        start_req(1'b0, 32'h0016_0040, 32'h0, 4'h0, 3'h4);
        serve(1'b0, 32'h0016_0040, 32'h0, 4'h0, 3'h4, TMO - 1, 1'b0, 0, 1'b0, 32'h0);
        // Timeout on a write, then the sticky flag until cleared.
        start_req(1'b1, 32'h0014_0020, 32'h1111_2222, 4'hC, 3'h0);
        serve(1'b1, 32'h0014_0020, 32'h1111_2222, 4'hC, 3'h0, 20, 1'b0, 0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", 64'(tmo_flag), 64'(1));
        clear_flag();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d;
            int j = $urandom_range(0, 8);
            int ws = ($urandom_range(0, 7) == 0) ? TMO + 5 : $urandom_range(0, 3);
            bit wr = 1'($urandom);
            logic [2:0] pr = 3'($urandom);
            a = (j < 7) ? rs[j] + ($urandom % (re[j] - rs[j] + 1)) : $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                pair(a, ws, 1'($urandom), rs[0] + ($urandom % 32'h200), d, 4'($urandom),
                     $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 2), 32'h0);
            end else begin
                start_req(wr, a, d, 4'($urandom), pr);
                serve(wr, a, d, 4'(wr ? w_strb : 4'h0), pr, ws, 1'($urandom),
                      $urandom_range(0, 2), 1'b0, 32'h0);
            end
            if ($urandom_range(0, 4) == 0) clear_flag();
        end

        // Timeout coinciding with a clear pulse: set wins.
        clear_flag();
        start_req(1'b0, 32'h0017_0100, 32'h0, 4'h0, 3'h3);
        serve(1'b0, 32'h0017_0100, 32'h0, 4'h0, 3'h3, 30, 1'b0, 0, 1'b1, 32'h0);
        @(negedge clk);
        chk("tmo_set_over_clr", 64'(tmo_flag), 64'(1));

        // Reset during ACCESS with the write request still asserted.
        cur_slave = 0; cur_ws = 30; cur_err = 1'b0;
        start_req(1'b1, 32'h0013_0020, 32'h7777_8888, 4'hF, 3'h0);
        #1;
        chk("mid_rst_accept", 64'(aw_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_in_access", 64'(penable), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_apb", 64'({pselx, penable}), 64'(0));
        chk("mid_rst_valids", 64'({b_valid, r_valid}), 64'(0));
        chk("mid_rst_idle", 64'({busy, tmo_flag}), 64'(0));
        chk("mid_rst_ready", 64'({aw_ready, w_ready}), 64'(0));
        aw_valid = 1'b0; w_valid = 1'b0;
        rst_n = 1'b1;
        cur_slave = -1;
        prio_wr = 1'b0;
        exp_tmo = 1'b0;
        @(negedge clk);
        pair(32'h0013_0300, 0, 1'b1, 32'h0013_0100, 32'hA5A5_5A5A, 4'h9, 0, 1'b0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
